uart_rx: RTL and testbench

- Oversampling UART receiver; the downstream counterpart of the UART transmitter.
- Recovers 8-bit frames from the serial line RX_IN: 1 start bit, 8 data bits LSB-first, optional parity bit, 1 stop bit.
- Each bit is majority-voted over three oversampled clocks.
- Delivers P_DATA with a one-cycle Data_Valid strobe and flags parity and stop-bit errors.
- Sits between the serial input pin (already synchronised to clk) and the system register/control logic.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rx_data_sampler.sv | 54 +++++
 rtl/uart_rx.sv | 114 +++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int PRESCALE_W = 6;

    // Parity type encodings shared with the transmitter
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/rx_data_sampler.sv
// rtl/rx_data_sampler.sv - per-bit edge counter with 3-sample majority vote
module rx_data_sampler
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  active,
    input  logic                  rx,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit,
    output logic                  sample_done,
    output logic                  bit_done
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [2:0]            samples;

    assign half        = prescale >> 1;
    assign sampled_bit = (samples[0] & samples[1]) |
                         (samples[0] & samples[2]) |
                         (samples[1] & samples[2]);

    // The start cycle is edge 0, so the counter resumes at 1 on the next edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt    <= '0;
            samples     <= '0;
            sample_done <= 1'b0;
            bit_done    <= 1'b0;
        end else begin
            sample_done <= 1'b0;
            bit_done    <= 1'b0;
            if (start) begin
                edge_cnt <= ONE;
            end else if (active) begin
                edge_cnt <= (edge_cnt == prescale - ONE) ? '0 : edge_cnt + ONE;
                if (edge_cnt == half - ONE) samples[0] <= rx;
                if (edge_cnt == half)       samples[1] <= rx;
                if (edge_cnt == half + ONE) begin
                    samples[2]  <= rx;
                    sample_done <= 1'b1;
                end
                if (edge_cnt == prescale - ONE) bit_done <= 1'b1;
            end else begin
                edge_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver: FSM, deserializer, parity/stop checks
module uart_rx
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int                BC_W     = $clog2(DATA_WIDTH);
    localparam logic [BC_W-1:0]   BC_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(DATA_WIDTH - 1);

    rx_state_e             state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BC_W-1:0]       bit_cnt;
    logic [PRESCALE_W-1:0] prescale_lat;
    logic                  par_en_lat;
    logic                  par_typ_lat;
    logic                  par_bad;
    logic                  start;
    logic                  active;
    logic                  sampled_bit;
    logic                  sample_done;
    logic                  bit_done;
    logic                  parity_exp;

    assign start      = (state == IDLE) && !RX_IN;
    assign active     = (state != IDLE);
    assign parity_exp = (^shift_reg) ^ (par_typ_lat == PAR_ODD);

    rx_data_sampler u_sampler (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .active      (active),
        .rx          (RX_IN),
        .prescale    (prescale_lat),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done),
        .bit_done    (bit_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            prescale_lat <= '0;
            par_en_lat   <= 1'b0;
            par_typ_lat  <= 1'b0;
            par_bad      <= 1'b0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state        <= START;
                        prescale_lat <= Prescale;
                        par_en_lat   <= PAR_EN;
                        par_typ_lat  <= PAR_TYP;
                        bit_cnt      <= '0;
                        par_bad      <= 1'b0;
                    end
                end
                START: begin
                    if (sample_done && sampled_bit) state <= IDLE;
                    else if (bit_done)              state <= DATA;
                end
                DATA: begin
                    if (sample_done) shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_done) begin
                        bit_cnt <= bit_cnt + BC_ONE;
                        if (bit_cnt == BC_LAST) state <= par_en_lat ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (sample_done && (sampled_bit != parity_exp)) begin
                        par_err <= 1'b1;
                        par_bad <= 1'b1;
                    end
                    if (bit_done) state <= STOP;
                end
                STOP: begin
                    // Decide at mid-bit and leave; the tail of the stop bit absorbs drift
                    if (sample_done) begin
                        if (!sampled_bit) begin
                            stp_err <= 1'b1;
                        end else if (!par_bad) begin
                            P_DATA     <= shift_reg;
                            Data_Valid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int tests = 0;
    int fails = 0;
    int both_high = 0;
    int cyc = 0;
    int b2b_idx;

    int         exp_dv_t[$];
    int         act_dv_t[$];
    logic [7:0] exp_dv_d[$];
    logic [7:0] act_dv_d[$];
    int         exp_pe_t[$];
    int         act_pe_t[$];
    int         exp_se_t[$];
    int         act_se_t[$];
    logic [7:0] last_good = 8'h00;

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .RX_IN      (rx_in),
        .Prescale   (prescale),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .Data_Valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    // cyc names the rising edge that just happened; a strobe set at edge X is seen with cyc == X
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            act_dv_t.push_back(cyc);
            act_dv_d.push_back(p_data);
        end
        if (par_err) act_pe_t.push_back(cyc);
        if (stp_err) act_se_t.push_back(cyc);
        if (data_valid && par_err) both_high++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            rx_in = 1'b1;
        end
    endtask

    task automatic glitch();
        @(negedge clk);
        check("glitch_pdata_before", p_data, last_good);
        prescale = 6'd8;
        par_en   = 1'b0;
        rx_in    = 1'b0;
        @(negedge clk);
        rx_in = 1'b0;
        repeat (6) begin
            @(negedge clk);
            rx_in = 1'b1;
        end
    endtask

    // Drives one whole frame; expected strobe times come from the frame-level timing rules
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptyp, input int p,
                              input bit flip_par, input bit stop_val, input bit cfg_toggle,
                              input int abort_at);
        int         n;
        int         t0;
        logic [10:0] fr;
        logic       par_bit;
        bit         good;
        n       = pen ? 11 : 10;
        par_bit = (($countones(d) % 2) == 1) ^ ptyp ^ flip_par;
        fr      = '1;
        fr[0]   = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = d[i];
        if (pen) begin
            fr[9]  = par_bit;
            fr[10] = stop_val;
        end else begin
            fr[9] = stop_val;
        end
        good = stop_val && !(pen && flip_par);

        @(negedge clk);
        check("pdata_hold", p_data, last_good);
        prescale = 6'(p);
        par_en   = pen;
        par_typ  = ptyp;
        rx_in    = 1'b0;
        t0       = cyc + 1;
        if (abort_at < 0) begin
            if (pen && flip_par) exp_pe_t.push_back(t0 + 9*p + p/2 + 2);
            if (!stop_val)       exp_se_t.push_back(t0 + (n-1)*p + p/2 + 2);
            if (good) begin
                exp_dv_t.push_back(t0 + (n-1)*p + p/2 + 2);
                exp_dv_d.push_back(d);
                last_good = d;
            end
        end
        for (int k = 1; k < n*p; k++) begin
            @(negedge clk);
            if (cfg_toggle && k == 2*p) begin
                par_en   = !par_en;
                par_typ  = !par_typ;
                prescale = 6'd8;
            end
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                check("rst_mid_pdata", p_data, 8'h00);
                check("rst_mid_dv", data_valid, 1'b0);
                check("rst_mid_pe", par_err, 1'b0);
                check("rst_mid_se", stp_err, 1'b0);
                last_good = 8'h00;
                repeat (3) @(negedge clk);
                rx_in = 1'b1;
                reset = 1'b1;
                return;
            end
            rx_in = fr[k/p];
        end
    endtask

    initial begin
        logic [7:0] d;
        int         p;
        bit         pen;
        bit         ptyp;
        bit         flip;
        bit         stp;
        int         m;

        reset    = 1'b0;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        #1;
        check("reset_pdata", p_data, 8'h00);
        check("reset_dv", data_valid, 1'b0);
        check("reset_pe", par_err, 1'b0);
        check("reset_se", stp_err, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b0, 8, 1'b0, 1'b1, 1'b0, -1);
        idle(3);
        glitch();
        send_frame(8'h3C, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, -1);
        idle(2);
        send_frame(8'h3C, 1'b1, 1'b1, 16, 1'b1, 1'b1, 1'b0, -1);
        idle(2);
        send_frame(8'h81, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0, -1);
        idle(10);

        b2b_idx = exp_dv_t.size();
        send_frame(8'h00, 1'b0, 1'b0, 32, 1'b0, 1'b1, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b0, 32, 1'b0, 1'b1, 1'b0, -1);
        idle(4);

        send_frame(8'hC3, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, 5*8 + 4);
        idle(20);
        send_frame(8'h5A, 1'b1, 1'b0, 8, 1'b0, 1'b1, 1'b0, -1);
        idle(3);

        for (int i = 0; i < 16; i++) begin
            d    = 8'($urandom);
            p    = 2 * $urandom_range(3, 16);
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            flip = ($urandom_range(0, 4) == 0);
            stp  = ($urandom_range(0, 5) != 0);
            send_frame(d, pen, ptyp, p, flip, stp, 1'b0, -1);
            // A low stop bit lingers past the decision and looks like a start; let it glitch out
            idle(stp ? $urandom_range(0, 3) : p + 2);
        end
        idle(40);

        check("dv_count", act_dv_t.size(), exp_dv_t.size());
        m = (act_dv_t.size() < exp_dv_t.size()) ? act_dv_t.size() : exp_dv_t.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("dv_time[%0d]", i), act_dv_t[i], exp_dv_t[i]);
            check($sformatf("dv_data[%0d]", i), act_dv_d[i], exp_dv_d[i]);
        end
        check("pe_count", act_pe_t.size(), exp_pe_t.size());
        m = (act_pe_t.size() < exp_pe_t.size()) ? act_pe_t.size() : exp_pe_t.size();
        for (int i = 0; i < m; i++) check($sformatf("pe_time[%0d]", i), act_pe_t[i], exp_pe_t[i]);
        check("se_count", act_se_t.size(), exp_se_t.size());
        m = (act_se_t.size() < exp_se_t.size()) ? act_se_t.size() : exp_se_t.size();
        for (int i = 0; i < m; i++) check($sformatf("se_time[%0d]", i), act_se_t[i], exp_se_t[i]);
        check("dv_pe_overlap", both_high, 0);
        if (act_dv_t.size() > b2b_idx + 1)
            check("b2b_spacing", act_dv_t[b2b_idx+1] - act_dv_t[b2b_idx], 320);
        else
            check("b2b_present", act_dv_t.size(), b2b_idx + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
